// File: rtl/dendrite_cfg_loader.sv
// Shifts a host-written L-word image into the compartment chain (deepest word first); DENDRITE_CFG_VERIFY_EN adds a read-back pass.
// Load takes P*L*2*CLK_DIV cycles after start; writes and start are ignored (wr_ready low) outside IDLE.
module dendrite_cfg_loader #(
  parameter int NUM_COMP       = 4,
  parameter int WORDS_PER_COMP = 3,
  parameter int WORD_LENGTH    = 16,
  parameter int CLK_DIV        = 2,
  localparam int L             = NUM_COMP * WORDS_PER_COMP,
  localparam int AW            = $clog2(L)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   verify_err,
  output logic                   cfg_data_clk,
  output logic [WORD_LENGTH-1:0] cfg_data_out,
  input  logic [WORD_LENGTH-1:0] cfg_chain_in
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] LAST = AW'(L - 1);
  localparam logic [AW:0] L_W = (AW + 1)'(L);
`ifdef DENDRITE_CFG_VERIFY_EN
  localparam logic LAST_PASS = 1'b1;
`else
  localparam logic LAST_PASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   pass_q, pass_d;
  logic [WORD_LENGTH-1:0] image_q [L];
  logic [WORD_LENGTH-1:0] image_d [L];
  logic [WORD_LENGTH-1:0] data_out_q, data_out_d;
  logic                   data_clk_q, data_clk_d;

  logic div_end, last_shift, accept_start, wr_hit;

  assign div_end      = (div_q == DIV_LAST);
  assign last_shift   = (idx_q == LAST) && (pass_q == LAST_PASS);
  assign accept_start = (state_q == IDLE) && start;
  assign wr_hit       = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < L_W);

  // Image next-value is also the source for the first word, so a write in the start cycle is seen.
  always_comb begin
    image_d = image_q;
    if (wr_hit) image_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = SHIFT_LO;
      SHIFT_LO: if (div_end) state_d = SHIFT_HI;
      SHIFT_HI: if (div_end) state_d = last_shift ? DONE : SHIFT_LO;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d      = '0;
    idx_d      = idx_q;
    pass_d     = pass_q;
    data_out_d = data_out_q;
    if ((state_d == state_q) && ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)))
      div_d = div_q + DW'(1);
    if (accept_start) begin
      idx_d      = '0;
      pass_d     = 1'b0;
      data_out_d = image_d[LAST];
    end else if ((state_q == SHIFT_HI) && div_end && !last_shift) begin
      if (idx_q == LAST) begin
        idx_d  = '0;
        pass_d = 1'b1;
      end else begin
        idx_d = idx_q + AW'(1);
      end
      data_out_d = image_q[LAST - idx_d];
    end
    data_clk_d = (state_d == SHIFT_HI);
  end

  always_comb begin
    wr_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      data_out_q <= '0;
      data_clk_q <= 1'b0;
      for (int i = 0; i < L; i++) image_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      data_out_q <= data_out_d;
      data_clk_q <= data_clk_d;
      for (int i = 0; i < L; i++) image_q[i] <= image_d[i];
    end
  end

  assign cfg_data_clk = data_clk_q;
  assign cfg_data_out = data_out_q;

`ifdef DENDRITE_CFG_VERIFY_EN
  logic verify_err_q, verify_err_d;

  // Tail shows image[L-1-j] just before second-pass rise j once pass one has filled the chain.
  always_comb begin
    verify_err_d = verify_err_q;
    if (accept_start)
      verify_err_d = 1'b0;
    else if ((state_q == SHIFT_LO) && div_end && pass_q && (cfg_chain_in != image_q[LAST - idx_q]))
      verify_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) verify_err_q <= 1'b0;
    else        verify_err_q <= verify_err_d;
  end

  assign verify_err = verify_err_q;
`else
  logic chain_unused;
  assign chain_unused = ^cfg_chain_in;
  assign verify_err   = 1'b0;
`endif

endmodule
